// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam int unsigned PC_INCR      = 4;
    localparam int unsigned BUBBLE_INSTR = 0;
    localparam int unsigned OPCODE_MSB   = 31;
    localparam int unsigned OPCODE_LSB   = 21;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a new entry, hold, or insert a bubble.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 64,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   bubble,
    input  logic [PC_WIDTH-1:0]    load_pc,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    output logic                   valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr
);

    // A bubble clears valid and instr but leaves pc untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= INSTR_WIDTH'(BUBBLE_INSTR);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, one-entry skid buffer and branch redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_WIDTH    = 64,
    parameter int unsigned     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   ifid_valid,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [10:0]            ifid_opcode
);

    fetch_state_t state, next_state;

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;

    logic ifid_load, ifid_bubble, from_skid;
    logic pc_inc, pc_to_target, pc_to_redirect;
    logic skid_capture, skid_clear, redirect_capture;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (flush)                    next_state = imem_ready ? FETCH : DRAIN;
                else if (imem_ready && stall) next_state = HOLD;
            end
            HOLD:  if (flush || !stall) next_state = FETCH;
            DRAIN: if (imem_ready)      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // A flush in DRAIN reuses the FETCH flush path: the in-flight word is dropped
    // and the newest target either becomes the PC or replaces redirect_pc.
    always_comb begin
        ifid_load        = 1'b0;
        ifid_bubble      = 1'b0;
        from_skid        = 1'b0;
        pc_inc           = 1'b0;
        pc_to_target     = 1'b0;
        pc_to_redirect   = 1'b0;
        skid_capture     = 1'b0;
        skid_clear       = 1'b0;
        redirect_capture = 1'b0;
        imem_req         = reset_n && (state != HOLD);
        case (state)
            FETCH, DRAIN: begin
                if (flush) begin
                    ifid_bubble      = 1'b1;
                    pc_to_target     = imem_ready;
                    redirect_capture = !imem_ready;
                end else if (state == DRAIN) begin
                    ifid_bubble    = 1'b1;
                    pc_to_redirect = imem_ready;
                end else if (imem_ready) begin
                    pc_inc       = 1'b1;
                    skid_capture = stall;
                    ifid_load    = !stall;
                end else begin
                    ifid_bubble = !stall;
                end
            end
            HOLD: begin
                if (flush) begin
                    ifid_bubble  = 1'b1;
                    skid_clear   = 1'b1;
                    pc_to_target = 1'b1;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    from_skid  = 1'b1;
                    skid_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            redirect_pc <= '0;
            skid_pc     <= '0;
            skid_instr  <= '0;
        end else begin
            if (pc_to_target)        pc <= branch_target;
            else if (pc_to_redirect) pc <= redirect_pc;
            else if (pc_inc)         pc <= pc + PC_WIDTH'(PC_INCR);
            if (redirect_capture) redirect_pc <= branch_target;
            if (skid_capture) begin
                skid_pc    <= pc;
                skid_instr <= imem_rdata;
            end else if (skid_clear) begin
                skid_pc    <= '0;
                skid_instr <= '0;
            end
        end
    end

    assign imem_addr = pc;

    ifid_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ifid (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .load_pc    (from_skid ? skid_pc : pc),
        .load_instr (from_skid ? skid_instr : imem_rdata),
        .valid      (ifid_valid),
        .pc         (ifid_pc),
        .instr      (ifid_instr)
    );

    assign ifid_opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];

endmodule
